lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller placed directly upstream of the data memory. It accepts one load or store request at a time from the execute stage over a valid/ready handshake, converts the byte address into a word index, and drives the memory's single address/write/data port. Stores narrower than a word use read-modify-write. Load results are sign- or zero-extended and returned over a valid/ready response channel. Sub-word stores use the memory's 1-cycle registered read: read, merge, write.

## Interface
- `ADDR`, default 16: word-index width of the data memory (shared constant).
- `WORD`, default 32: data width. Must be 32 because lane logic assumes 4 bytes.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept. Equals `state==IDLE`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `req_signed` in 1: sign-extend the load result. Ignored for stores.
- `req_addr` in ADDR+2: byte address.
- `req_wdata` in WORD: store data, right-aligned.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out WORD: load result. 0 for stores and errors.
- `resp_err` out 1: misaligned access or reserved size.
- `mem_a` out ADDR: word index, `addr[ADDR+1:2]`.
- `mem_w` out 1: write strobe.
- `mem_d` out WORD: write data.
- `mem_q` in WORD: read data, valid the cycle after a read cycle.

## Operation
- The controller holds one request at a time. A request is accepted on `req_valid && req_ready`. At acceptance it latches `we`, `size`, `signed`, `addr` and `wdata`.
- Error check at acceptance:
  - size 11 is an error.
  - half with `addr[0]=1` is an error.
  - word with `addr[1:0]!=0` is an error.
  - An error goes IDLE→RESP with `resp_err=1` and `resp_rdata=0`. Memory is not touched.
- Load: IDLE→RD→RDW→RESP.
  - RD: `mem_w=0` and `mem_a` = index.
  - RDW: `mem_q` is valid. Extract the lane, extend it, and register it into `resp_rdata`.
- Word store: IDLE→WR→RESP. In WR, `mem_w=1` and `mem_d=wdata`.
- Sub-word store: IDLE→RD→RDW→WR→RESP.
  - RDW registers the merge: `mem_q` with the new byte or half replacing its lanes.
  - WR writes the merged word.
- Lanes are little-endian:
  - byte k = bits [8k+7:8k], with k = `addr[1:0]`.
  - half = bits [16h+15:16h], with h = `addr[1]`.
  - Zero-extend or sign-extend the result to 32 bits according to `req_signed`.
- RESP holds `resp_valid=1` with `resp_rdata`/`resp_err` stable until `resp_ready`, then returns to IDLE.
- Outside the WR state `mem_w=0`, so the memory performs a harmless read every cycle.
- `mem_a` always reflects the latched index.
- `req_valid` outside IDLE is ignored. No request is ever dropped.

## Timing
- Cycle counts are measured from the acceptance edge to the first `resp_valid` cycle:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- The write lands at the edge ending the WR cycle.
- Minimum request spacing is the response latency plus 1. RESP never accepts a new request in the same cycle.
- Reset values: state IDLE, `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `mem_a=0`, `mem_d=0`, `mem_w=0`. `req_ready=1` from the first cycle after reset.
- `mem_w` is gated by `~rst`. A reset during WR produces no write.
- Reset mid-operation abandons the request with no response. A sub-word store reset in RD/RDW leaves memory unchanged.
- `resp_ready` held low keeps RESP indefinitely with outputs stable.

## Structure
- Shared params include: `ADDR`, `WORD`, size encodings `SZ_B`/`SZ_H`/`SZ_W`, and state encodings IDLE/RD/RDW/WR/RESP.
- Sub-module `lsu_lane_fmt` (combinational): inputs `mem_q`, `wdata`, `size`, `addr[1:0]`, `signed`. Outputs the extended load value and the merged store word.
- `lsu_ctrl` holds the FSM, request latch and response registers.

## Test plan
- Store word 0xDEADBEEF at addr 0x10, then load word signed from 0x10. Expect: write at index 4, 2-cycle store response, then `resp_rdata=0xDEADBEEF` 3 cycles after acceptance.
- Store byte 0x5A at addr 0x13 over 0x11223344, then load word. Expect: the read-modify-write sequence, 0x5A223344 at index 4, store response after 4 cycles.
- With 0x0000F080 at index 0: load byte at addr 0x01 signed → 0xFFFFFFF0. Load byte at 0x00 unsigned → 0x00000080. Load half at 0x00 signed → 0xFFFFF080.
- Load half at addr 0x03, then store with size 11. Expect: each `resp_err=1`, `resp_rdata=0`, 1-cycle latency, `mem_w` never high.
- Hold `resp_ready=0` for 5 cycles with `req_valid` pulsing. Expect: response stable, `req_ready=0`, no second access. Then release and confirm the next request completes.
- Assert `rst` during the WR cycle of a sub-word store. Expect: `mem_w` stays 0, memory unchanged, all outputs at reset values, `req_ready=1` next cycle.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared constants and types for the load/store controller.
//   ADDR  : word-index width of the data memory
//   WORD  : data width (lane logic assumes four bytes)
//   SZ_*  : request size encodings
//   state_t : controller FSM states
package lsu_ctrl_pkg;

  localparam int ADDR = 16;
  localparam int WORD = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  // A request is rejected for the reserved size or for an address that
  // is not naturally aligned to its size.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      SZ_R:    bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Combinational lane formatter for the load/store controller.
//   mem_q      : word read from memory
//   wdata      : right-aligned store data
//   size       : SZ_B / SZ_H / SZ_W
//   addr_lo    : byte offset within the word
//   sgn        : sign-extend the load value
//   load_val   : selected lane, zero- or sign-extended to a word
//   store_word : mem_q with the store data merged into its lanes
module lsu_lane_fmt
  import lsu_ctrl_pkg::*;
(
  input  logic [WORD-1:0] mem_q,
  input  logic [WORD-1:0] wdata,
  input  logic [1:0]      size,
  input  logic [1:0]      addr_lo,
  input  logic            sgn,
  output logic [WORD-1:0] load_val,
  output logic [WORD-1:0] store_word
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Little-endian lanes: byte k at bits [8k+7:8k], half h at [16h+15:16h].
  always_comb begin
    byte_sh = {addr_lo, 3'b000};
    half_sh = {addr_lo[1], 4'b0000};
    byte_v  = mem_q[byte_sh +: 8];
    half_v  = mem_q[half_sh +: 16];

    case (size)
      SZ_B:    load_val = {{24{sgn & byte_v[7]}}, byte_v};
      SZ_H:    load_val = {{16{sgn & half_v[15]}}, half_v};
      default: load_val = mem_q;
    endcase

    store_word = mem_q;
    case (size)
      SZ_B:    store_word[byte_sh +: 8]  = wdata[7:0];
      SZ_H:    store_word[half_sh +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of a single-port data memory with a
// 1-cycle registered read.
//   req_*      : request channel (valid/ready), byte address, size, data
//   resp_*     : response channel (valid/ready), load data, error flag
//   mem_a/w/d  : memory word index, write strobe, write data
//   mem_q      : memory read data, valid the cycle after a read cycle
//   dbg_state  : current FSM state
// Handshake: a transfer happens on a rising edge where valid && ready;
// the producer keeps valid and payload stable until then, and the
// consumer may drive ready independently of valid.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [ADDR+1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [WORD-1:0] resp_rdata,
  output logic            resp_err,
  output logic [ADDR-1:0] mem_a,
  output logic            mem_w,
  output logic [WORD-1:0] mem_d,
  input  logic [WORD-1:0] mem_q,
  output logic [2:0]      dbg_state
);

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic [ADDR+1:0] addr_q, addr_d;
  logic [WORD-1:0] wdata_q, wdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [WORD-1:0] resp_rdata_q, resp_rdata_d;
  logic            mem_w_q, mem_w_d;
  logic [WORD-1:0] mem_d_q, mem_d_d;
  logic [WORD-1:0] load_val, store_word;

  lsu_lane_fmt u_lane_fmt (
    .mem_q      (mem_q),
    .wdata      (wdata_q),
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .sgn        (sgn_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_w_d      = 1'b0;
    mem_d_d      = mem_d_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d         = req_we;
          size_d       = req_size;
          sgn_d        = req_signed;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          if (req_is_bad(req_size, req_addr[1:0])) begin
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else if (req_we && (req_size == SZ_W)) begin
            // Full-word stores skip the read and write directly.
            mem_d_d = req_wdata;
            mem_w_d = 1'b1;
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      // mem_a already carries the latched index; the memory reads it now.
      RD: state_d = RDW;
      RDW: begin
        if (we_q) begin
          mem_d_d = store_word;
          mem_w_d = 1'b1;
          state_d = WR;
        end else begin
          resp_rdata_d = load_val;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      WR: begin
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_B;
      sgn_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_w_q      <= 1'b0;
      mem_d_q      <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_w_q      <= mem_w_d;
      mem_d_q      <= mem_d_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_a      = addr_q[ADDR+1:2];
  // Gating with rst keeps a reset asserted during WR from writing.
  assign mem_w      = mem_w_q & ~rst;
  assign mem_d      = mem_d_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [15:0] mem_a;
  logic        mem_w;
  logic [31:0] mem_d, mem_q;
  logic [2:0]  dbg_state;

  logic [31:0] mem [0:65535];
  logic [31:0] ref_mem [0:65535];

  logic [32:0] exp_q[$];    // {err, rdata}
  logic [47:0] exp_wr_q[$]; // {index, data}

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_a(mem_a), .mem_w(mem_w), .mem_d(mem_d), .mem_q(mem_q),
    .dbg_state(dbg_state)
  );

  // Data memory with a registered read.
  always @(posedge clk) begin
    if (mem_w) mem[mem_a] <= mem_d;
    mem_q <= mem[mem_a];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model(input logic we, input logic [1:0] sz, input logic sg,
                                input logic [17:0] a, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd,
                                output logic wr, output logic [31:0] wv, output int lat);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w   = ref_mem[a[17:2]];
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    rd  = 32'h0;
    wr  = 1'b0;
    wv  = 32'h0;
    case (a[1:0])
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 3;
      if (sz == 2'b00)      rd = sg ? {{24{b[7]}}, b} : {24'h0, b};
      else if (sz == 2'b01) rd = sg ? {{16{h[15]}}, h} : {16'h0, h};
      else                  rd = w;
    end else begin
      wr = 1'b1;
      if (sz == 2'b10) begin
        lat = 2;
        wv  = wd;
      end else begin
        lat = 4;
        wv  = w;
        if (sz == 2'b00) begin
          case (a[1:0])
            2'd0: wv[7:0]   = wd[7:0];
            2'd1: wv[15:8]  = wd[7:0];
            2'd2: wv[23:16] = wd[7:0];
            default: wv[31:24] = wd[7:0];
          endcase
        end else if (a[1]) begin
          wv[31:16] = wd[15:0];
        end else begin
          wv[15:0] = wd[15:0];
        end
      end
    end
  endfunction

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) check("resp_unexp", {31'h0, resp_valid}, 64'h0);
      else check("resp", {resp_err, resp_rdata}, {31'h0, exp_q.pop_front()});
    end
    if (mem_w) begin
      if (exp_wr_q.size() == 0) check("wr_unexp", {63'h0, mem_w}, 64'h0);
      else check("wr", {mem_a, mem_d}, {16'h0, exp_wr_q.pop_front()});
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [17:0] a, input logic [31:0] wd, input bit hold);
    logic        err, wr;
    logic [31:0] rd, wv;
    int          lat, n;
    model(we, sz, sg, a, wd, err, rd, wr, wv, lat);
    exp_q.push_back({err, rd});
    if (wr) begin
      exp_wr_q.push_back({a[17:2], wv});
      ref_mem[a[17:2]] = wv;
    end
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("ready_timeout", {63'h0, req_ready}, 64'h1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // Scramble the request inputs to prove the request was latched.
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = $urandom_range(0, 3);
    req_signed = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    check("latency", n, lat);
    if (!hold) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
    check("rst_resp_err", {63'h0, resp_err}, 64'h0);
    check("rst_rdata", {32'h0, resp_rdata}, 64'h0);
    check("rst_mem_a", {48'h0, mem_a}, 64'h0);
    check("rst_mem_d", {32'h0, mem_d}, 64'h0);
    check("rst_mem_w", {63'h0, mem_w}, 64'h0);
    check("rst_req_ready", {63'h0, req_ready}, 64'h1);
    check("rst_state", {61'h0, dbg_state}, {61'h0, IDLE});
    @(posedge clk); #1;

    // Word store then signed word load.
    do_req(1'b1, 2'b10, 1'b0, 18'h10, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 2'b10, 1'b1, 18'h10, 32'h0, 1'b0);
    check("mem_idx4", {32'h0, mem[4]}, 64'hDEADBEEF);

    // Byte read-modify-write into lane 3.
    do_req(1'b1, 2'b10, 1'b0, 18'h10, 32'h11223344, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 18'h13, 32'hFFFFFF5A, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 18'h10, 32'h0, 1'b0);
    check("mem_rmw", {32'h0, mem[4]}, 64'h5A223344);

    // Extension cases.
    do_req(1'b1, 2'b10, 1'b0, 18'h00, 32'h0000F080, 1'b0);
    do_req(1'b0, 2'b00, 1'b1, 18'h01, 32'h0, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 18'h00, 32'h0, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 18'h00, 32'h0, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 18'h02, 32'h0000ABCD, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 18'h02, 32'h0, 1'b0);

    // Errors: misaligned half, reserved size, misaligned word.
    do_req(1'b0, 2'b01, 1'b1, 18'h03, 32'h0, 1'b0);
    do_req(1'b1, 2'b11, 1'b0, 18'h04, 32'h12345678, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 18'h06, 32'h12345678, 1'b0);

    // Response back-pressure with request pulses that must be ignored.
    resp_ready = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, 18'h10, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid = i[0]; req_we = 1'b1; req_size = 2'b10; req_addr = 18'h20; req_wdata = 32'h12345678;
      @(negedge clk);
      check("stall_valid", {63'h0, resp_valid}, 64'h1);
      check("stall_data", {31'h0, resp_err, resp_rdata}, {31'h0, exp_q[0]});
      check("stall_ready", {63'h0, req_ready}, 64'h0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    do_req(1'b1, 2'b10, 1'b0, 18'h20, 32'hCAFEF00D, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 18'h20, 32'h0, 1'b0);

    // Reset during the WR cycle of a byte store.
    do_req(1'b1, 2'b10, 1'b0, 18'h24, 32'h01020304, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 18'h25; req_wdata = 32'h000000AB;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_wr_mem_w", {63'h0, mem_w}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_mem_w", {63'h0, mem_w}, 64'h0);
    check("rst2_resp_valid", {63'h0, resp_valid}, 64'h0);
    check("rst2_rdata", {32'h0, resp_rdata}, 64'h0);
    check("rst2_mem_a", {48'h0, mem_a}, 64'h0);
    check("rst2_mem_d", {32'h0, mem_d}, 64'h0);
    check("rst2_req_ready", {63'h0, req_ready}, 64'h1);
    check("rst2_mem_kept", {32'h0, mem[9]}, {32'h0, ref_mem[9]});
    @(posedge clk); #1;

    // Random traffic over a small window of addresses.
    for (int i = 0; i < 40; i++) begin
      do_req($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
             18'($urandom_range(0, 63)), $urandom, 1'b0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("resp_q_left", exp_q.size(), 64'h0);
    check("wr_q_left", exp_wr_q.size(), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
